// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the regfile_ctrl instruction sequencer.
// REGFILE_CTRL_CMP_EN enables CMP support in the decoder and controller.
package regfile_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_DECODE,
    ST_WR_IMM,
    ST_GET_A,
    ST_GET_B,
    ST_ALU,
    ST_WR_REG
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b01;

  // Exactly one flag is set for any instruction word.
  typedef struct packed {
    logic mov_imm;
    logic mov_reg;
    logic mvn;
    logic arith;    // ADD or AND: reads both Rn and Rm, writes Rd
    logic cmp;
    logic illegal;
  } insn_class_t;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/regfile_ctrl_if.sv
// Instruction handshake and register-file/datapath control bundle for regfile_ctrl.
// Signal set is the same with or without REGFILE_CTRL_CMP_EN.
interface regfile_ctrl_if;
  logic        s;
  logic [15:0] in;
  logic        w;
  logic [2:0]  writenum;
  logic        write;
  logic [2:0]  readnum;
  logic [1:0]  vsel;
  logic [15:0] sximm8;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  aluop;
  logic        illegal;

  modport master (
    output s, in,
    input  w, writenum, write, readnum, vsel, sximm8,
           loada, loadb, loadc, loads, asel, bsel, shift, aluop, illegal
  );

  modport slave (
    input  s, in,
    output w, writenum, write, readnum, vsel, sximm8,
           loada, loadb, loadc, loads, asel, bsel, shift, aluop, illegal
  );
endinterface

// File: rtl/regfile_ctrl_insn_decode.sv
// Combinational field extraction and instruction classification of the latched word.
// CMP (101/01) is recognised only when REGFILE_CTRL_CMP_EN is defined.
module insn_decode
  import regfile_ctrl_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [1:0]  sh,
  output logic [1:0]  op,
  output logic [15:0] sximm8,
  output insn_class_t cls
);

  logic [2:0] opcode;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = sext8(ir[7:0]);

  always_comb begin
    cls         = '0;
    cls.mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    cls.mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    cls.mvn     = (opcode == OPC_ALU) && (op == OP_MVN);
    cls.arith   = (opcode == OPC_ALU) && ((op == OP_ADD) || (op == OP_AND));
`ifdef REGFILE_CTRL_CMP_EN
    cls.cmp     = (opcode == OPC_ALU) && (op == OP_CMP);
`else
    cls.cmp     = 1'b0;
`endif
    cls.illegal = !(cls.mov_imm || cls.mov_reg || cls.mvn || cls.arith || cls.cmp);
  end

endmodule

// File: rtl/regfile_ctrl.sv
// Moore sequencer issuing register-file reads, operand/result loads and writes per instruction.
// Define REGFILE_CTRL_CMP_EN to support CMP; otherwise 101/01 is illegal and loads stays 0.
module regfile_ctrl
  import regfile_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  regfile_ctrl_if.slave bus
);

  state_t      state_reg;
  logic [15:0] ir_reg;

  logic [2:0]  rn, rd, rm;
  logic [1:0]  sh, op;
  logic [15:0] sximm8;
  insn_class_t cls;

  logic        w_reg;
  logic        write_reg;
  logic [2:0]  writenum_reg;
  logic [2:0]  readnum_reg;
  logic [1:0]  vsel_reg;
  logic        loada_reg, loadb_reg, loadc_reg;
  logic        asel_reg, bsel_reg;
  logic [1:0]  shift_reg, aluop_reg;
`ifdef REGFILE_CTRL_CMP_EN
  logic        loads_reg;
`endif

  insn_decode u_decode (
    .ir     (ir_reg),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .sh     (sh),
    .op     (op),
    .sximm8 (sximm8),
    .cls    (cls)
  );

  // Outputs are registered alongside the state they belong to, so each is
  // computed from the state being entered; readnum/writenum/vsel hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_WAIT;
      ir_reg       <= '0;
      w_reg        <= 1'b1;
      write_reg    <= 1'b0;
      writenum_reg <= '0;
      readnum_reg  <= '0;
      vsel_reg     <= VSEL_C;
      loada_reg    <= 1'b0;
      loadb_reg    <= 1'b0;
      loadc_reg    <= 1'b0;
      asel_reg     <= 1'b0;
      bsel_reg     <= 1'b0;
      shift_reg    <= '0;
      aluop_reg    <= '0;
`ifdef REGFILE_CTRL_CMP_EN
      loads_reg    <= 1'b0;
`endif
    end else begin
      w_reg     <= 1'b0;
      write_reg <= 1'b0;
      loada_reg <= 1'b0;
      loadb_reg <= 1'b0;
      loadc_reg <= 1'b0;
      asel_reg  <= 1'b0;
      bsel_reg  <= 1'b0;
      shift_reg <= '0;
      aluop_reg <= '0;
`ifdef REGFILE_CTRL_CMP_EN
      loads_reg <= 1'b0;
`endif
      case (state_reg)
        ST_WAIT: begin
          if (bus.s) begin
            ir_reg    <= bus.in;
            state_reg <= ST_DECODE;
          end else begin
            w_reg <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (cls.mov_imm) begin
            state_reg    <= ST_WR_IMM;
            write_reg    <= 1'b1;
            writenum_reg <= rn;
            vsel_reg     <= VSEL_IMM;
          end else if (cls.mov_reg || cls.mvn) begin
            state_reg   <= ST_GET_B;
            readnum_reg <= rm;
            loadb_reg   <= 1'b1;
          end else if (cls.arith || cls.cmp) begin
            state_reg   <= ST_GET_A;
            readnum_reg <= rn;
            loada_reg   <= 1'b1;
          end else begin
            state_reg <= ST_WAIT;
            w_reg     <= 1'b1;
          end
        end
        ST_GET_A: begin
          state_reg   <= ST_GET_B;
          readnum_reg <= rm;
          loadb_reg   <= 1'b1;
        end
        ST_GET_B: begin
          state_reg <= ST_ALU;
          loadc_reg <= 1'b1;
          asel_reg  <= cls.mov_reg || cls.mvn;
          shift_reg <= sh;
          aluop_reg <= cls.mov_reg ? 2'b00 : op;
`ifdef REGFILE_CTRL_CMP_EN
          loads_reg <= cls.cmp;
`endif
        end
        ST_ALU: begin
          if (cls.cmp) begin
            state_reg <= ST_WAIT;
            w_reg     <= 1'b1;
          end else begin
            state_reg    <= ST_WR_REG;
            write_reg    <= 1'b1;
            writenum_reg <= rd;
            vsel_reg     <= VSEL_C;
          end
        end
        default: begin
          state_reg <= ST_WAIT;
          w_reg     <= 1'b1;
        end
      endcase
    end
  end

  assign bus.w        = w_reg;
  assign bus.write    = write_reg;
  assign bus.writenum = writenum_reg;
  assign bus.readnum  = readnum_reg;
  assign bus.vsel     = vsel_reg;
  assign bus.sximm8   = sximm8;
  assign bus.loada    = loada_reg;
  assign bus.loadb    = loadb_reg;
  assign bus.loadc    = loadc_reg;
  assign bus.asel     = asel_reg;
  assign bus.bsel     = bsel_reg;
  assign bus.shift    = shift_reg;
  assign bus.aluop    = aluop_reg;
`ifdef REGFILE_CTRL_CMP_EN
  assign bus.loads    = loads_reg;
`else
  assign bus.loads    = 1'b0;
`endif
  // The illegal pulse needs the latched word, which only exists once DECODE
  // is entered, so it is decoded from registered state and ir.
  assign bus.illegal  = (state_reg == ST_DECODE) && cls.illegal;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed scoreboard bench for regfile_ctrl: expected strobe cycles are queued per instruction.
// Follows REGFILE_CTRL_CMP_EN so the same bench covers both builds.
module tb_regfile_ctrl;

  logic clk;
  logic reset_n;

  regfile_ctrl_if bus ();

  regfile_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef REGFILE_CTRL_CMP_EN
  localparam bit CMP_EN = 1'b1;
`else
  localparam bit CMP_EN = 1'b0;
`endif

  typedef struct packed {
    logic        write;
    logic [2:0]  writenum;
    logic [2:0]  readnum;
    logic [1:0]  vsel;
    logic [15:0] sximm8;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic        illegal;
  } ev_t;

  ev_t        q[$];
  logic [2:0] m_wn;
  logic [2:0] m_rn;
  int         checks;
  int         passes;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic ev_t base_ev();
    ev_t e;
    e          = '0;
    e.writenum = m_wn;
    e.readnum  = m_rn;
    return e;
  endfunction

  // Reference model: queue the strobe cycles an instruction must produce.
  task automatic push_insn(input logic [15:0] x, output int lat);
    logic [2:0]  opc, rn, rd, rm;
    logic [1:0]  op, sh;
    logic [15:0] imm;
    logic        mov_imm, mov_reg, mvn, arith, cmp;
    ev_t         e;
    opc = x[15:13]; op = x[12:11]; rn = x[10:8]; rd = x[7:5]; sh = x[4:3]; rm = x[2:0];
    imm = {{8{x[7]}}, x[7:0]};
    mov_imm = (opc == 3'b110) && (op == 2'b10);
    mov_reg = (opc == 3'b110) && (op == 2'b00);
    mvn     = (opc == 3'b101) && (op == 2'b11);
    arith   = (opc == 3'b101) && ((op == 2'b00) || (op == 2'b10));
    cmp     = (opc == 3'b101) && (op == 2'b01) && CMP_EN;
    if (mov_imm) begin
      m_wn = rn;
      e = base_ev(); e.write = 1'b1; e.vsel = 2'b01; e.sximm8 = imm;
      q.push_back(e);
      lat = 3;
    end else if (mov_reg || mvn || arith || cmp) begin
      if (arith || cmp) begin
        m_rn = rn;
        e = base_ev(); e.loada = 1'b1;
        q.push_back(e);
      end
      m_rn = rm;
      e = base_ev(); e.loadb = 1'b1;
      q.push_back(e);
      e = base_ev(); e.loadc = 1'b1; e.loads = cmp; e.asel = mov_reg || mvn;
      e.shift = sh; e.aluop = mov_reg ? 2'b00 : op;
      q.push_back(e);
      if (!cmp) begin
        m_wn = rd;
        e = base_ev(); e.write = 1'b1; e.vsel = 2'b00; e.sximm8 = imm;
        q.push_back(e);
      end
      lat = arith ? 6 : 5;
    end else begin
      e = base_ev(); e.illegal = 1'b1;
      q.push_back(e);
      lat = 2;
    end
  endtask

  // Monitor: every cycle with an active strobe must match the head of the queue.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && (bus.write | bus.loada | bus.loadb | bus.loadc |
                             bus.loads | bus.asel | bus.bsel | bus.illegal)) begin
      ev_t o;
      o.write = bus.write; o.writenum = bus.writenum; o.readnum = bus.readnum;
      o.vsel = bus.write ? bus.vsel : 2'b00;
      o.sximm8 = bus.write ? bus.sximm8 : 16'h0000;
      o.loada = bus.loada; o.loadb = bus.loadb; o.loadc = bus.loadc; o.loads = bus.loads;
      o.asel = bus.asel; o.bsel = bus.bsel;
      o.shift = bus.loadc ? bus.shift : 2'b00;
      o.aluop = bus.loadc ? bus.aluop : 2'b00;
      o.illegal = bus.illegal;
      if (q.size() == 0) check("unexpected_event", 64'(o), 64'(0));
      else check("event", 64'(o), 64'(q.pop_front()));
    end
  end

  // Accept one instruction, then measure edges from acceptance to the edge sampling w=1.
  task automatic run_insn(input string tag, input logic [15:0] x);
    int lat;
    int cnt;
    @(negedge clk);
    push_insn(x, lat);
    bus.in = x;
    bus.s  = 1'b1;
    @(negedge clk);
    bus.s  = 1'b0;
    bus.in = 16'hFFFF;
    cnt = 1;
    while (bus.w !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_latency"}, 64'(cnt), 64'(lat));
  endtask

  initial begin
    int lat;
    checks  = 0;
    passes  = 0;
    m_wn    = '0;
    m_rn    = '0;
    reset_n = 1'b0;
    bus.s   = 1'b0;
    bus.in  = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_w",        64'(bus.w),        64'(1));
    check("rst_strobes",  64'({bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads,
                                bus.asel, bus.bsel, bus.illegal}), 64'(0));
    check("rst_nums",     64'({bus.writenum, bus.readnum}), 64'(0));
    check("rst_vsel_ops", 64'({bus.vsel, bus.shift, bus.aluop}), 64'(0));
    check("rst_sximm8",   64'(bus.sximm8), 64'(0));
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_w", 64'(bus.w), 64'(1));

    run_insn("mov_imm",  16'hD3FE);
    run_insn("add",      16'hA148);
    run_insn("mov_reg",  16'hC0F2);
    run_insn("mvn",      16'hB881);
    run_insn("and",      16'hB5C4);
    run_insn("cmp",      16'hA900);
    run_insn("illegal0", 16'h0000);
    run_insn("illegal1", 16'hC800);

    // s held high across two MOV imm words; in changes while the first runs
    @(negedge clk);
    push_insn(16'hD3FE, lat);
    bus.in = 16'hD3FE;
    bus.s  = 1'b1;
    @(negedge clk);
    push_insn(16'hD512, lat);
    bus.in = 16'hD512;
    check("b2b_busy", 64'(bus.w), 64'(0));
    repeat (2) @(negedge clk);
    check("b2b_wait", 64'(bus.w), 64'(1));
    @(negedge clk);
    check("b2b_no_bubble", 64'(bus.w), 64'(0));
    bus.s = 1'b0;
    repeat (2) @(negedge clk);
    check("b2b_done", 64'(bus.w), 64'(1));

    // Abort an ADD during GET_B with an asynchronous reset
    @(negedge clk);
    push_insn(16'hA148, lat);
    bus.in = 16'hA148;
    bus.s  = 1'b1;
    @(negedge clk);
    bus.s = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_in_get_b", 64'(bus.loadb), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_w",       64'(bus.w), 64'(1));
    check("abort_strobes", 64'({bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads,
                                 bus.asel, bus.bsel, bus.illegal}), 64'(0));
    check("abort_nums",    64'({bus.writenum, bus.readnum}), 64'(0));
    q.delete();
    m_wn = '0;
    m_rn = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_idle_w", 64'(bus.w), 64'(1));

    run_insn("post_abort_mov", 16'hD512);
    repeat (2) @(negedge clk);
    check("queue_empty", 64'(q.size()), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

endmodule
